// File: rtl/lcd_stream_reader.sv
// Decodes a 17-bit token stream (frame/row markers plus RGB565 pixels) from a
// source FIFO into coordinate-tagged pixels with valid/ready flow control.
module lcd_stream_reader #(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        queue_empty,
  input  logic [16:0] queue_data,
  output logic        queue_rd_en,
  input  logic        pixel_ready,
  output logic        pixel_valid,
  output logic [15:0] pixel_data,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        frame_start,
  output logic        frame_done,
  output logic        sync_error,
  output logic [7:0]  error_count
);

  localparam logic [16:0] TOK_FS = 17'h10000;
  localparam logic [16:0] TOK_RS = 17'h10001;
  localparam logic [16:0] TOK_FE = 17'h1FFFF;
  localparam logic [10:0] LAST_COL = 11'(FRAME_WIDTH - 1);
  localparam logic [10:0] ROWS     = 11'(FRAME_HEIGHT);

  typedef enum logic [1:0] {WAIT_FRAME, WAIT_ROW, PIXELS, WAIT_END} state_t;

  state_t      state, state_nx;
  logic [10:0] row, row_nx, col, col_nx;
  logic        rd_pending;
  logic        push, pop;
  logic        fs_nx, fd_nx, err_nx;

  logic [15:0] buf_data [2];
  logic [10:0] buf_x    [2];
  logic [10:0] buf_y    [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic [1:0]  occupancy;

  logic is_fs, is_rs, is_fe, is_px;
  assign is_fs = (queue_data == TOK_FS);
  assign is_rs = (queue_data == TOK_RS);
  assign is_fe = (queue_data == TOK_FE);
  assign is_px = ~queue_data[16];

  assign pixel_valid = (count != 2'd0);
  assign pixel_data  = buf_data[rd_ptr];
  assign pixel_x     = buf_x[rd_ptr];
  assign pixel_y     = buf_y[rd_ptr];
  assign pop         = pixel_valid & pixel_ready;

  // The slot freed by this cycle's pop is counted as available, which keeps
  // the stream at one pixel per cycle while pixel_ready stays high.
  assign occupancy   = count - {1'b0, pop} + {1'b0, rd_pending};
  assign queue_rd_en = ~rst & ~queue_empty & (occupancy < 2'd2);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    push     = 1'b0;
    fs_nx    = 1'b0;
    fd_nx    = 1'b0;
    err_nx   = 1'b0;
    if (rd_pending) begin
      if (is_fs && state != WAIT_FRAME) begin
        err_nx   = 1'b1;
        fs_nx    = 1'b1;
        row_nx   = '0;
        col_nx   = '0;
        state_nx = WAIT_ROW;
      end else begin
        unique case (state)
          WAIT_FRAME: begin
            if (is_fs) begin
              fs_nx    = 1'b1;
              row_nx   = '0;
              state_nx = WAIT_ROW;
            end
          end
          WAIT_ROW: begin
            if (is_rs) begin
              col_nx   = '0;
              state_nx = PIXELS;
            end else if (is_fe && row == ROWS) begin
              fd_nx    = 1'b1;
              state_nx = WAIT_FRAME;
            end else begin
              err_nx   = 1'b1;
              state_nx = WAIT_FRAME;
            end
          end
          PIXELS: begin
            if (is_px) begin
              push = 1'b1;
              if (col == LAST_COL) begin
                col_nx   = col + 11'd1;
                row_nx   = row + 11'd1;
                state_nx = (row + 11'd1 == ROWS) ? WAIT_END : WAIT_ROW;
              end else begin
                col_nx = col + 11'd1;
              end
            end else begin
              err_nx   = 1'b1;
              state_nx = WAIT_FRAME;
            end
          end
          WAIT_END: begin
            if (is_fe) fd_nx = 1'b1;
            else       err_nx = 1'b1;
            state_nx = WAIT_FRAME;
          end
          default: state_nx = WAIT_FRAME;
        endcase
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_FRAME;
      row         <= '0;
      col         <= '0;
      rd_pending  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      sync_error  <= 1'b0;
      error_count <= '0;
    end else begin
      state       <= state_nx;
      row         <= row_nx;
      col         <= col_nx;
      rd_pending  <= queue_rd_en;
      frame_start <= fs_nx;
      frame_done  <= fd_nx;
      sync_error  <= err_nx;
      if (err_nx && error_count != 8'hFF) error_count <= error_count + 8'd1;
    end
  end

  // NOTE: the two buffer entries are reset because they drive the pixel
  // outputs directly, which must read zero while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_x[i]    <= '0;
        buf_y[i]    <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= queue_data[15:0];
        buf_x[wr_ptr]    <= col;
        buf_y[wr_ptr]    <= row;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_lcd_stream_reader.sv
// Randomized bench for lcd_stream_reader: a token-level reference model predicts
// pixels, pulses and error counts; a FIFO model feeds the DUT token stream.
module tb_lcd_stream_reader;

  localparam int W = 4;
  localparam int H = 2;
  localparam logic [16:0] TOK_FS = 17'h10000;
  localparam logic [16:0] TOK_RS = 17'h10001;
  localparam logic [16:0] TOK_FE = 17'h1FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        queue_empty;
  logic [16:0] queue_data;
  logic        queue_rd_en;
  logic        pixel_ready;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        frame_start;
  logic        frame_done;
  logic        sync_error;
  logic [7:0]  error_count;

  lcd_stream_reader #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .queue_empty(queue_empty), .queue_data(queue_data), .queue_rd_en(queue_rd_en),
    .pixel_ready(pixel_ready), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .frame_done(frame_done),
    .sync_error(sync_error), .error_count(error_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [10:0] x;
    logic [10:0] y;
  } pix_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [16:0] src[$];
  pix_t        exp_q[$];
  int exp_fs, exp_fd, exp_err, exp_coinc;
  int got_fs, got_fd, got_err, got_coinc, got_px;
  int ready_mode;
  bit rand_empty, track_occ;
  int occ_viol, hold_viol, empty_viol, buffered;
  bit last_rd, last_rd_pix, prev_stall;
  pix_t prev_pix;
  int last_cycles;

  // Reference: walk the token list once with plain frame/row/column bookkeeping.
  function automatic void model(input logic [16:0] toks[$]);
    bit in_frame = 0;
    bit in_row = 0;
    int row = 0;
    int col = 0;
    pix_t p;
    foreach (toks[i]) begin
      if (toks[i] == TOK_FS) begin
        if (in_frame) begin
          exp_err++;
          exp_coinc++;
        end
        exp_fs++;
        in_frame = 1;
        in_row = 0;
        row = 0;
      end else if (in_frame) begin
        if (in_row && !toks[i][16]) begin
          p = {toks[i][15:0], 11'(col), 11'(row)};
          exp_q.push_back(p);
          col++;
          if (col == W) begin
            in_row = 0;
            row++;
          end
        end else if (!in_row && row < H && toks[i] == TOK_RS) begin
          in_row = 1;
          col = 0;
        end else if (!in_row && row == H && toks[i] == TOK_FE) begin
          exp_fd++;
          in_frame = 0;
        end else begin
          exp_err++;
          in_frame = 0;
        end
      end
    end
  endfunction

  function automatic logic [16:0] rand_pix();
    return {1'b0, 16'($urandom)};
  endfunction

  task automatic add_row(input int n);
    src.push_back(TOK_RS);
    for (int i = 0; i < n; i++) src.push_back(rand_pix());
  endtask

  task automatic add_frame();
    src.push_back(TOK_FS);
    for (int r = 0; r < H; r++) add_row(W);
    src.push_back(TOK_FE);
  endtask

  task automatic clear_track();
    last_rd = 0; last_rd_pix = 0; prev_stall = 0; buffered = 0;
    occ_viol = 0; hold_viol = 0; empty_viol = 0;
  endtask

  // One clock: sample at the falling edge, drive new inputs just after the rising edge.
  task automatic step();
    bit rd;
    logic [16:0] tok;
    pix_t e;
    pix_t cur;
    @(negedge clk);
    rd  = queue_rd_en && !queue_empty;
    cur = {pixel_data, pixel_x, pixel_y};
    if (queue_rd_en && queue_empty) empty_viol++;
    if (track_occ && rd && last_rd && buffered >= 2) occ_viol++;
    if (prev_stall && (!pixel_valid || cur != prev_pix)) hold_viol++;
    prev_stall = pixel_valid && !pixel_ready;
    prev_pix = cur;
    if (pixel_valid && pixel_ready) begin
      got_px++;
      buffered--;
      if (exp_q.size() == 0) check("px_extra", 64'(cur), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("px", 64'(cur), 64'(e));
      end
    end
    if (last_rd && last_rd_pix) buffered++;
    got_fs  += int'(frame_start);
    got_fd  += int'(frame_done);
    got_err += int'(sync_error);
    if (sync_error && frame_start) got_coinc++;
    tok = '0;
    if (rd && src.size() != 0) tok = src.pop_front();
    last_rd = rd;
    last_rd_pix = rd && !tok[16];
    @(posedge clk);
    #1;
    queue_data  = rd ? tok : 17'($urandom);
    pixel_ready = (ready_mode == 2) ? 1'($urandom) : (ready_mode == 1);
    queue_empty = (src.size() == 0) || (rand_empty && $urandom_range(2) == 0);
  endtask

  task automatic do_reset(input bit check_state);
    rst = 1'b1;
    queue_empty = 1'b0;
    queue_data = TOK_FS;
    pixel_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check_state) begin
      check("rst_rd_en", 64'(queue_rd_en), 64'(0));
      check("rst_valid", 64'(pixel_valid), 64'(0));
      check("rst_data", 64'(pixel_data), 64'(0));
      check("rst_x", 64'(pixel_x), 64'(0));
      check("rst_y", 64'(pixel_y), 64'(0));
      check("rst_fs", 64'(frame_start), 64'(0));
      check("rst_fd", 64'(frame_done), 64'(0));
      check("rst_err", 64'(sync_error), 64'(0));
      check("rst_cnt", 64'(error_count), 64'(0));
    end
    rst = 1'b0;
    queue_empty = 1'b1;
    clear_track();
  endtask

  task automatic run(input string name, input int rmode, input bit remp, input bit occ,
                     input int budget);
    int cyc;
    exp_q.delete();
    exp_fs = 0; exp_fd = 0; exp_err = 0; exp_coinc = 0;
    got_fs = 0; got_fd = 0; got_err = 0; got_coinc = 0; got_px = 0;
    ready_mode = rmode;
    rand_empty = remp;
    track_occ = occ;
    model(src);
    cyc = 0;
    while ((src.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      step();
      cyc++;
    end
    last_cycles = cyc;
    check({name, "_timeout"}, 64'(cyc >= budget), 64'(0));
    ready_mode = 1;
    repeat (4) step();
    check({name, "_frame_start"}, 64'(got_fs), 64'(exp_fs));
    check({name, "_frame_done"}, 64'(got_fd), 64'(exp_fd));
    check({name, "_sync_error"}, 64'(got_err), 64'(exp_err));
    check({name, "_error_count"}, 64'(error_count), 64'((exp_err > 255) ? 255 : exp_err));
    check({name, "_restart_coinc"}, 64'(got_coinc), 64'(exp_coinc));
    check({name, "_hold"}, 64'(hold_viol), 64'(0));
    check({name, "_rd_when_empty"}, 64'(empty_viol), 64'(0));
    if (occ) check({name, "_rd_overcommit"}, 64'(occ_viol), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    queue_empty = 1'b1;
    queue_data = '0;
    pixel_ready = 1'b0;
    ready_mode = 1;
    clear_track();

    // Reset state, then one clean frame at full rate.
    do_reset(1'b1);
    add_frame();
    run("basic", 1, 1'b0, 1'b1, 200);
    check("basic_pixels", 64'(got_px), 64'(W * H));
    check("basic_rate", 64'(last_cycles <= W * H + H + 2 + 6), 64'(1));

    // Random backpressure and source gaps.
    for (int k = 0; k < 3; k++) begin
      do_reset(1'b0);
      add_frame();
      add_frame();
      run("stall", 2, 1'b1, 1'b1, 400);
      check("stall_pixels", 64'(got_px), 64'(2 * W * H));
    end

    // Leading tokens before the first frame start are dropped silently.
    do_reset(1'b0);
    src.push_back(TOK_FE);
    src.push_back(17'h00005);
    src.push_back(TOK_RS);
    add_frame();
    run("leading", 2, 1'b0, 1'b0, 300);

    // Short row, then a clean frame.
    do_reset(1'b0);
    src.push_back(TOK_FS);
    add_row(3);
    src.push_back(TOK_RS);
    add_frame();
    run("short_row", 2, 1'b0, 1'b0, 300);
    check("short_row_pixels", 64'(got_px), 64'(3 + W * H));

    // Frame start while receiving pixels restarts the frame.
    do_reset(1'b0);
    src.push_back(TOK_FS);
    add_row(2);
    src.push_back(TOK_FS);
    for (int r = 0; r < H; r++) add_row(W);
    src.push_back(TOK_FE);
    run("restart", 2, 1'b1, 1'b0, 300);

    // Random token soup interleaved with clean frames.
    for (int k = 0; k < 2; k++) begin
      do_reset(1'b0);
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(7))
          0: src.push_back(TOK_FS);
          1: src.push_back(TOK_RS);
          2: src.push_back(TOK_FE);
          3: src.push_back(17'h10002 + 17'($urandom_range(16'hFFF0)));
          4: add_frame();
          default: src.push_back(rand_pix());
        endcase
      end
      add_frame();
      run("random", 2, 1'b1, 1'b0, 2000);
    end

    // Repeated frame starts drive the error counter into saturation.
    do_reset(1'b0);
    for (int i = 0; i < 262; i++) src.push_back(TOK_FS);
    run("saturate", 1, 1'b0, 1'b0, 800);

    // Reset mid-row with two pixels buffered.
    do_reset(1'b0);
    src.push_back(TOK_FS);
    add_row(2);
    exp_q.delete();
    ready_mode = 0;
    rand_empty = 1'b0;
    track_occ = 1'b0;
    repeat (8) step();
    check("midrst_buffered", 64'(pixel_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(pixel_valid), 64'(0));
    check("midrst_count", 64'(error_count), 64'(0));
    check("midrst_rd_en", 64'(queue_rd_en), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_track();
    src.push_back(rand_pix());
    src.push_back(rand_pix());
    add_row(W);
    add_frame();
    run("after_rst", 2, 1'b0, 1'b0, 300);
    check("after_rst_pixels", 64'(got_px), 64'(W * H));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_stream_reader.md
LCD_STREAM_READER -- requirements
Module: lcd_stream_reader

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 480, pixels per row.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 272, rows per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port queue_empty  input  1  source FIFO empty.
REQ-006 SHALL have port queue_data  input  17  FIFO Q; valid the cycle after a read is accepted.
REQ-007 SHALL have port queue_rd_en  output  1  FIFO read request.
REQ-008 SHALL have port pixel_ready  input  1  downstream accepts a pixel.
REQ-009 SHALL have port pixel_valid  output  1  pixel_data, pixel_x and pixel_y are valid.
REQ-010 SHALL have port pixel_data  output  16  RGB565 pixel.
REQ-011 SHALL have port pixel_x  output  11  column of pixel_data.
REQ-012 SHALL have port pixel_y  output  11  row of pixel_data.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse when a frame-start token is decoded.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when a well-formed frame-end token is decoded.
REQ-015 SHALL have port sync_error  output  1  one-cycle pulse when a stream violation is detected.
REQ-016 SHALL have port error_count  output  8  saturating count of violations.

Function
REQ-017 SHALL decode tokens as follows:
- 17'h10000: frame start.
- 17'h10001: row start.
- 17'h1FFFF: frame end.
- bit16=0: pixel, with data in bits 15:0.
- any other value with bit16=1: invalid.
REQ-018 SHALL hold a read in flight for exactly one cycle: the token is captured on the cycle after queue_rd_en=1 with queue_empty=0.
REQ-019 SHALL assert queue_rd_en only when queue_empty=0 and (buffered pixels + reads in flight) < 2.
REQ-020 SHALL buffer pixels in a 2-entry output FIFO so back-to-back reads are never lost under pixel_ready stall; sustained throughput is 1 pixel/cycle when pixel_ready=1.
REQ-021 SHALL hold pixel_valid/data/x/y stable while pixel_valid=1 and pixel_ready=0.
REQ-022 SHALL implement states WAIT_FRAME, WAIT_ROW, PIXELS, WAIT_END.
REQ-023 WAIT_FRAME: frame start -> WAIT_ROW with row=0 and frame_start pulse; all other tokens SHALL be discarded silently.
REQ-024 WAIT_ROW: row start -> PIXELS with col=0; frame end when row==FRAME_HEIGHT -> frame_done pulse and WAIT_FRAME; any other token is a violation.
REQ-025 PIXELS: pixel -> buffered with x=col and y=row, col+1; when col reaches FRAME_WIDTH, row+1 and -> WAIT_ROW, or -> WAIT_END if row+1==FRAME_HEIGHT.
REQ-026 WAIT_END: frame end -> frame_done pulse and WAIT_FRAME; any other token is a violation.
REQ-027 SHALL treat a frame start in any state other than WAIT_FRAME as a violation that also restarts the frame (row=0, WAIT_ROW, frame_start pulse in the same cycle as sync_error).
REQ-028 On any other violation (early row start, early frame end, extra pixel, invalid token) SHALL pulse sync_error, increment error_count saturating at 255, and go to WAIT_FRAME.
REQ-029 SHALL keep pixels already buffered before a violation and deliver them normally.
REQ-030 frame_done SHALL pulse in the cycle after the frame-end token is captured, independent of pixel buffer drain.

Reset
REQ-031 While rst=1 SHALL force:
- state=WAIT_FRAME; output buffer empty; in-flight read cleared.
- queue_rd_en=0, pixel_valid=0, pixel_data=0, pixel_x=0, pixel_y=0.
- frame_start=0, frame_done=0, sync_error=0, error_count=0.
REQ-032 Reset asserted mid-frame SHALL discard any in-flight token and all buffered pixels; after release, decoding resumes only at the next frame start.

Verification
REQ-033 FRAME_WIDTH=4, FRAME_HEIGHT=2; stream 10000,10001,4 pixels,10001,4 pixels,1FFFF with pixel_ready=1 -> 8 pixels with (x,y)=(0..3,0),(0..3,1); one frame_start; one frame_done; error_count=0.
REQ-034 Same stream with pixel_ready toggling randomly -> identical pixel sequence, no loss or duplication; queue_rd_en never asserted with 2 pixels buffered plus one read in flight.
REQ-035 Stream 1FFFF, 0005, 10001, then a valid frame -> leading tokens discarded; error_count=0; one frame_done.
REQ-036 Row with 3 pixels followed by 10001 -> sync_error pulse, error_count=1, 3 pixels still output, next frame decodes cleanly.
REQ-037 10000 received while in PIXELS -> sync_error and frame_start in the same cycle, error_count=1, row/col restart at 0.
REQ-038 Assert rst mid-row with 2 pixels buffered -> pixel_valid=0 immediately, error_count=0; pixels arriving before the next 10000 are ignored.
